// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel strobe divider, h/v counters, syncs, active and start pulses.
// Optional frame counter enabled by defining VGA_FRAME_COUNTER_EN.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned CLK_DIV  = 4,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned HW       = 10,
  parameter int unsigned VW       = 10
) (
  input  logic          CLK100MHZ,
  input  logic          reset,
  output logic          pix_en,
  output logic [HW-1:0] hCount,
  output logic [VW-1:0] vCount,
  output logic          hSync,
  output logic          vSync,
  output logic          active,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_FRAME_COUNTER_EN
  ,
  output logic [15:0]   frame_count
`endif
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC - 1;
  localparam int unsigned DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if (H_TOTAL > (2 ** HW)) begin : g_h_total_chk
    $error("vga_timing_gen: H_TOTAL does not fit in HW bits");
  end
  if (V_TOTAL > (2 ** VW)) begin : g_v_total_chk
    $error("vga_timing_gen: V_TOTAL does not fit in VW bits");
  end
  if (CLK_DIV < 1) begin : g_clk_div_chk
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end

  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] h_count_q, h_count_d;
  logic [VW-1:0] v_count_q, v_count_d;
  logic          h_sync_q, h_sync_d;
  logic          v_sync_q, v_sync_d;
  logic          active_q, active_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;

  assign pix_en = (div_q == DW'(CLK_DIV - 1));

  // Syncs/active are decoded from the next counter values so they line up with the counters.
  always_comb begin
    div_d         = div_q;
    h_count_d     = h_count_q;
    v_count_d     = v_count_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (pix_en) div_d = '0;
    else        div_d = div_q + DW'(1);

    if (pix_en) begin
      if (h_count_q == HW'(H_TOTAL - 1)) begin
        h_count_d = '0;
        if (v_count_q == VW'(V_TOTAL - 1)) v_count_d = '0;
        else                               v_count_d = v_count_q + VW'(1);
      end else begin
        h_count_d = h_count_q + HW'(1);
      end
      line_start_d  = (h_count_d == '0);
      frame_start_d = (h_count_d == '0) && (v_count_d == '0);
    end

    h_sync_d = ((32'(h_count_d) >= HS_START) && (32'(h_count_d) <= HS_END)) ? H_POL : ~H_POL;
    v_sync_d = ((32'(v_count_d) >= VS_START) && (32'(v_count_d) <= VS_END)) ? V_POL : ~V_POL;
    active_d = (32'(h_count_d) < H_ACTIVE) && (32'(v_count_d) < V_ACTIVE);
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      div_q         <= '0;
      h_count_q     <= HW'(H_TOTAL - 1);
      v_count_q     <= VW'(V_TOTAL - 1);
      h_sync_q      <= ~H_POL;
      v_sync_q      <= ~V_POL;
      active_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_count_q     <= h_count_d;
      v_count_q     <= v_count_d;
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      active_q      <= active_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hCount      = h_count_q;
  assign vCount      = v_count_q;
  assign hSync       = h_sync_q;
  assign vSync       = v_sync_q;
  assign active      = active_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

`ifdef VGA_FRAME_COUNTER_EN
  logic [15:0] frame_count_q, frame_count_d;
  logic        seen_frame_q, seen_frame_d;

  // The first frame after reset is frame 0; later frame starts advance the count.
  always_comb begin
    frame_count_d = frame_count_q;
    seen_frame_d  = seen_frame_q;
    if (frame_start_d) begin
      if (seen_frame_q) frame_count_d = frame_count_q + 16'd1;
      else              seen_frame_d  = 1'b1;
    end
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      frame_count_q <= '0;
      seen_frame_q  <= 1'b0;
    end else begin
      frame_count_q <= frame_count_d;
      seen_frame_q  <= seen_frame_d;
    end
  end

  assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small 16x8 raster at CLK_DIV=2 against a scoreboard model,
// plus a CLK_DIV=1 instance checked for strobe level, pulse widths and periods.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       pix_en, h_sync, v_sync, active, line_start, frame_start;
  logic [3:0] h_count;
  logic [2:0] v_count;
  logic       pix_en1, h_sync1, v_sync1, active1, line_start1, frame_start1;
  logic [3:0] h_count1;
  logic [2:0] v_count1;
`ifdef VGA_FRAME_COUNTER_EN
  logic [15:0] frame_count, frame_count1;
`endif

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .CLK_DIV(2), .H_POL(1'b0), .V_POL(1'b0), .HW(4), .VW(3)
  ) dut (
    .CLK100MHZ(clk), .reset(rst), .pix_en(pix_en), .hCount(h_count), .vCount(v_count),
    .hSync(h_sync), .vSync(v_sync), .active(active), .line_start(line_start),
    .frame_start(frame_start)
`ifdef VGA_FRAME_COUNTER_EN
    , .frame_count(frame_count)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .CLK_DIV(1), .H_POL(1'b0), .V_POL(1'b0), .HW(4), .VW(3)
  ) dut1 (
    .CLK100MHZ(clk), .reset(rst), .pix_en(pix_en1), .hCount(h_count1), .vCount(v_count1),
    .hSync(h_sync1), .vSync(v_sync1), .active(active1), .line_start(line_start1),
    .frame_start(frame_start1)
`ifdef VGA_FRAME_COUNTER_EN
    , .frame_count(frame_count1)
`endif
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state for the CLK_DIV=2 instance
  int   m_div, m_h, m_v, m_fc;
  logic m_ls, m_fs, m_seen;
  logic [13:0] sb_q[$];

  int   cyc, last_ls, last_fs, last_ls1, last_fs1;
  int   hs_low, act_low, vs_low;
  logic prev_ls1, prev_fs1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_div = 0; m_h = 15; m_v = 7; m_fc = 0;
    m_ls = 1'b0; m_fs = 1'b0; m_seen = 1'b0;
    sb_q.delete();
  endtask

  task automatic tracker_reset();
    cyc = 0; last_ls = -1; last_fs = -1; last_ls1 = -1; last_fs1 = -1;
    hs_low = 0; act_low = 0; vs_low = 0;
    prev_ls1 = 1'b0; prev_fs1 = 1'b0;
  endtask

  task automatic model_step();
    logic pe;
    pe = (m_div == 1);
    m_div = pe ? 0 : m_div + 1;
    m_ls = 1'b0;
    m_fs = 1'b0;
    if (pe) begin
      if (m_h == 15) begin
        m_h = 0;
        m_v = (m_v == 7) ? 0 : m_v + 1;
      end else begin
        m_h = m_h + 1;
      end
      m_ls = (m_h == 0);
      m_fs = (m_h == 0) && (m_v == 0);
      if (m_fs) begin
        if (m_seen) m_fc = (m_fc + 1) & 32'hFFFF;
        else        m_seen = 1'b1;
      end
    end
  endtask

  function automatic logic [13:0] model_vec();
    logic pe, hs, vs, act;
    pe  = (m_div == 1);
    hs  = !((m_h >= 10) && (m_h <= 11));
    vs  = !(m_v == 5);
    act = (m_h < 8) && (m_v < 4);
    return {pe, 4'(m_h), 3'(m_v), hs, vs, act, m_ls, m_fs};
  endfunction

  // One system clock: predict at the edge, compare at the following falling edge.
  task automatic tick();
    logic [13:0] e, o;
    @(posedge clk);
    model_step();
    sb_q.push_back(model_vec());
    @(negedge clk);
    cyc++;
    e = sb_q.pop_front();
    o = {pix_en, h_count, v_count, h_sync, v_sync, active, line_start, frame_start};
    chk("scoreboard", 32'(o), 32'(e));
    if (!h_sync) hs_low++;
    if (!active) act_low++;
    if (!v_sync) vs_low++;
    if (line_start) begin
      if (last_ls >= 0) chk("line_period", 32'(cyc - last_ls), 32'd32);
      last_ls = cyc;
    end
    if (frame_start) begin
      if (last_fs >= 0) chk("frame_period", 32'(cyc - last_fs), 32'd256);
      last_fs = cyc;
`ifdef VGA_FRAME_COUNTER_EN
      chk("frame_count", 32'(frame_count), 32'(m_fc));
`endif
    end
    chk("pix_en1_const", 32'(pix_en1), 32'd1);
    if (frame_start1) begin
      chk("fs1_width", 32'(prev_fs1), 32'd0);
      if (last_fs1 >= 0) chk("frame1_period", 32'(cyc - last_fs1), 32'd128);
      last_fs1 = cyc;
    end
    if (line_start1) begin
      chk("ls1_width", 32'(prev_ls1), 32'd0);
      if (last_ls1 >= 0) chk("line1_period", 32'(cyc - last_ls1), 32'd16);
      last_ls1 = cyc;
    end
    prev_fs1 = frame_start1;
    prev_ls1 = line_start1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pix_en"}, 32'(pix_en), 32'd0);
    chk({tag, "_hcount"}, 32'(h_count), 32'd15);
    chk({tag, "_vcount"}, 32'(v_count), 32'd7);
    chk({tag, "_hsync"}, 32'(h_sync), 32'd1);
    chk({tag, "_vsync"}, 32'(v_sync), 32'd1);
    chk({tag, "_active"}, 32'(active), 32'd0);
    chk({tag, "_line_start"}, 32'(line_start), 32'd0);
    chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    chk({tag, "_pix_en1"}, 32'(pix_en1), 32'd1);
    chk({tag, "_hcount1"}, 32'(h_count1), 32'd15);
    chk({tag, "_vcount1"}, 32'(v_count1), 32'd7);
`ifdef VGA_FRAME_COUNTER_EN
    chk({tag, "_frame_count"}, 32'(frame_count), 32'd0);
`endif
  endtask

  task automatic release_sequence(input string tag);
    tick();
    chk({tag, "_pix_en_c1"}, 32'(pix_en), 32'd1);
    tick();
    chk({tag, "_hcount_c2"}, 32'(h_count), 32'd0);
    chk({tag, "_vcount_c2"}, 32'(v_count), 32'd0);
    chk({tag, "_line_start_c2"}, 32'(line_start), 32'd1);
    chk({tag, "_frame_start_c2"}, 32'(frame_start), 32'd1);
    chk({tag, "_active_c2"}, 32'(active), 32'd1);
    chk({tag, "_hsync_c2"}, 32'(h_sync), 32'd1);
    chk({tag, "_vsync_c2"}, 32'(v_sync), 32'd1);
    hs_low = 0; act_low = 0;
    tick();
    chk({tag, "_line_start_c3"}, 32'(line_start), 32'd0);
    chk({tag, "_frame_start_c3"}, 32'(frame_start), 32'd0);
  endtask

  initial begin
    bit found;
    model_reset();
    tracker_reset();
    #23;
    check_reset_vals("rst");
    @(negedge clk);
    rst = 1'b0;

    release_sequence("rel");

    // Rest of line 0 (cycles 3..33)
    repeat (30) tick();
    chk("line_hsync_low_clocks", 32'(hs_low), 32'd4);
    chk("line_inactive_clocks", 32'(act_low), 32'd16);

    // Rest of frame 0 up to its last cycle, then the wrap
    vs_low = 0;
    repeat (224) tick();
    chk("frame_vsync_low_clocks", 32'(vs_low), 32'd32);
    chk("wrap_h_before", 32'(h_count), 32'd15);
    chk("wrap_v_before", 32'(v_count), 32'd7);
    tick();
    chk("wrap_h_after", 32'(h_count), 32'd0);
    chk("wrap_v_after", 32'(v_count), 32'd0);
    chk("wrap_frame_start", 32'(frame_start), 32'd1);

    // Two more frames so the frame counter reaches 2
    repeat (512) tick();

`ifdef VGA_FRAME_COUNTER_EN
    force dut.frame_count_q = 16'hFFFF;
    m_fc = 32'hFFFF;
    tick();
    release dut.frame_count_q;
    chk("fc_preload", 32'(frame_count), 32'hFFFF);
    repeat (255) tick();
    chk("fc_wrap", 32'(frame_count), 32'd0);
`endif

    // Advance into a line until hCount is 5
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      tick();
      if (h_count == 4'd5) found = 1'b1;
    end
    chk("reach_hcount5", 32'(found), 32'd1);

    #2 rst = 1'b1;
    #1 check_reset_vals("async");
    model_reset();
    tracker_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    release_sequence("rerel");
    repeat (300) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, horizontal sync width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync width in lines.
- V_BP, 33, vertical back porch in lines.
- CLK_DIV, 4, CLK100MHZ cycles per pixel (allowed range >=1).
- H_POL, 0, asserted level of hSync.
- V_POL, 0, asserted level of vSync.
- HW, 10, hCount width.
- VW, 10, vCount width.
REQ-002 Ports (name, direction, width, meaning), one per line, clock and reset first:
- CLK100MHZ, in, 1, system clock.
- reset, in, 1, reset; asynchronous, active-high.
- pix_en, out, 1, pixel strobe.
- hCount, out, HW, pixel column.
- vCount, out, VW, line.
- hSync, out, 1, horizontal sync.
- vSync, out, 1, vertical sync.
- active, out, 1, inside the visible area.
- line_start, out, 1, line-start pulse.
- frame_start, out, 1, frame-start pulse.
- frame_count, out, 16, frame counter (present only with the macro in REQ-016).
REQ-003 The design SHALL use one clock, CLK100MHZ. Reset SHALL be asynchronous and active-high on port reset.

Function
REQ-004 Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP. H_TOTAL SHALL be at most 2^HW and V_TOTAL at most 2^VW; elaboration SHALL fail otherwise.
REQ-005 Divider counter div:
- counts 0 to CLK_DIV-1 and wraps.
- pix_en SHALL be the combinational decode (div == CLK_DIV-1).
- With CLK_DIV=1, pix_en SHALL be constant 1 after reset.
REQ-006 Counter advance:
- On a rising edge with pix_en=1, hCount SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and vCount SHALL advance.
- vCount SHALL wrap from V_TOTAL-1 to 0.
- With pix_en=0, the counters SHALL hold.
REQ-007 hSync, vSync and active SHALL be registered and consistent with hCount/vCount in the same cycle (zero relative latency).
REQ-008 hSync SHALL equal H_POL when hCount is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], otherwise ~H_POL. vSync follows the same rule using the V parameters and vCount.
REQ-009 active SHALL be 1 iff hCount<H_ACTIVE and vCount<V_ACTIVE.
REQ-010 line_start SHALL be high for exactly one CLK100MHZ cycle: the cycle in which hCount first equals 0. frame_start SHALL be high for one cycle when (hCount,vCount) first equals (0,0). The two pulses coincide at frame start.
REQ-011 Each pulse SHALL last one system clock regardless of CLK_DIV. No pulse SHALL repeat during the CLK_DIV-1 hold cycles that follow.

Reset
REQ-012 While reset=1, all outputs SHALL take these values:
- div=0, pix_en=0 (1 if CLK_DIV=1).
- hCount=H_TOTAL-1, vCount=V_TOTAL-1.
- hSync=~H_POL, vSync=~V_POL, active=0.
- line_start=0, frame_start=0, frame_count=0.
REQ-013 The first pix_en edge after reset release SHALL wrap the counters to (0,0) and raise line_start and frame_start. Frame 0 therefore starts complete.
REQ-014 Reset asserted mid-frame SHALL force the REQ-012 values immediately, without waiting for a clock edge.

Configuration
REQ-015 Macro VGA_FRAME_COUNTER_EN SHALL control the frame counter.
REQ-016 With VGA_FRAME_COUNTER_EN defined:
- port frame_count SHALL exist.
- It SHALL increment by 1 in the cycle frame_start is asserted, except the first frame_start after reset, which leaves it at 0.
- It SHALL wrap from 65535 to 0.
REQ-017 Without the macro, the frame_count port and its logic SHALL be absent. All other behaviour SHALL be identical.

Verification
Bench parameters for REQ-018 to REQ-022: H 8/2/2/4 (total 16), V 4/1/1/2 (total 8), CLK_DIV=2, H_POL=V_POL=0.
REQ-018 Release reset and run 2 clocks:
- pix_en high on the 1st cycle.
- Counters (0,0) after the 2nd edge.
- frame_start=line_start=1 for 1 cycle.
- active=1, hSync=vSync=1.
REQ-019 Run one line: hSync=0 exactly while hCount is 10..11 (4 system clocks). active=0 while hCount is 8..15. line_start recurs every 32 clocks.
REQ-020 Run one frame:
- vSync=0 only while vCount=5 (32 clocks).
- frame_start recurs every 256 clocks.
- Counters wrap (15,7) -> (0,0).
REQ-021 With VGA_FRAME_COUNTER_EN defined, run 3 frames: frame_count reads 0, 1, 2 at the successive frame_starts. Preload 65535 and check wrap to 0.
REQ-022 Assert reset asynchronously mid-line at hCount=5: outputs take the REQ-012 values before the next edge. After release, REQ-018 repeats exactly.
REQ-023 Rerun with CLK_DIV=1: pix_en is constant 1, the frame lasts 128 clocks, and each pulse is still one cycle wide.
